// File: rtl/mem_arbiter.sv
`default_nettype none
// ---------------------------------------------------------------------------
// mem_arbiter : two-requester (fetch / data) sequencer for one 64-bit memory port
// Revision    : 1.0
// ---------------------------------------------------------------------------
module mem_arbiter #(
  parameter int STARVE_LIMIT = 4
) (
  input  logic        i_clk,
  input  logic        i_rst,

  input  logic        i_if_req,
  input  logic [63:0] i_if_addr,
  output logic        o_if_gnt,
  output logic        o_if_valid,
  output logic [31:0] o_if_rdata,

  input  logic        i_d_req,
  input  logic [63:0] i_d_addr,
  input  logic [7:0]  i_d_rmask,
  input  logic [7:0]  i_d_wmask,
  input  logic [63:0] i_d_wdata,
  output logic        o_d_gnt,
  output logic        o_d_valid,
  output logic [63:0] o_d_rdata,

  output logic        o_mem_req,
  output logic [63:0] o_mem_addr,
  output logic [7:0]  o_mem_rmask,
  output logic [7:0]  o_mem_wmask,
  output logic [63:0] o_mem_wdata,
  input  logic        i_mem_ready,
  input  logic        i_mem_valid,
  input  logic [63:0] i_mem_rdata,

  output logic        o_busy
);

  localparam int CNT_W = $clog2(STARVE_LIMIT + 1);
  localparam logic [CNT_W-1:0] c_limit = CNT_W'(STARVE_LIMIT);

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_REQ  = 2'd1,
    ST_WAIT = 2'd2,
    ST_RESP = 2'd3
  } state_t;

  state_t           r_state;
  state_t           w_next;
  logic [CNT_W-1:0] r_starve_cnt;
  logic             r_owner_d;
  logic             r_word_hi;
  logic             w_grant_if;
  logic             w_grant_d;
  logic             w_unused_addr_lsb;

  assign w_unused_addr_lsb = ^i_if_addr[1:0];

  // Data wins unless fetch has been passed over STARVE_LIMIT times in a row.
  always_comb begin
    w_grant_if = 1'b0;
    w_grant_d  = 1'b0;
    if (r_state == ST_IDLE) begin
      w_grant_if = i_if_req && (!i_d_req || (r_starve_cnt == c_limit));
      w_grant_d  = i_d_req && !w_grant_if;
    end
  end

  always_comb begin
    w_next = r_state;
    case (r_state)
      ST_IDLE: if (w_grant_if || w_grant_d) w_next = ST_REQ;
      ST_REQ:  if (i_mem_ready)             w_next = ST_WAIT;
      ST_WAIT: if (i_mem_valid)             w_next = ST_RESP;
      ST_RESP:                              w_next = ST_IDLE;
      default:                              w_next = ST_IDLE;
    endcase
  end

  always_ff @(posedge i_clk) begin
    if (i_rst) r_state <= ST_IDLE;
    else       r_state <= w_next;
  end

  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      r_starve_cnt <= '0;
      r_owner_d    <= 1'b0;
      r_word_hi    <= 1'b0;
      o_if_gnt     <= 1'b0;
      o_d_gnt      <= 1'b0;
      o_if_valid   <= 1'b0;
      o_d_valid    <= 1'b0;
      o_if_rdata   <= '0;
      o_d_rdata    <= '0;
      o_mem_addr   <= '0;
      o_mem_rmask  <= '0;
      o_mem_wmask  <= '0;
      o_mem_wdata  <= '0;
    end else begin
      o_if_gnt   <= 1'b0;
      o_d_gnt    <= 1'b0;
      o_if_valid <= 1'b0;
      o_d_valid  <= 1'b0;
      case (r_state)
        ST_IDLE: begin
          if (w_grant_if) begin
            o_if_gnt     <= 1'b1;
            r_owner_d    <= 1'b0;
            r_word_hi    <= i_if_addr[2];
            r_starve_cnt <= '0;
            o_mem_addr   <= {i_if_addr[63:3], 3'b000};
            o_mem_rmask  <= i_if_addr[2] ? 8'hF0 : 8'h0F;
            o_mem_wmask  <= 8'h00;
            o_mem_wdata  <= '0;
          end else if (w_grant_d) begin
            o_d_gnt     <= 1'b1;
            r_owner_d   <= 1'b1;
            r_word_hi   <= 1'b0;
            o_mem_addr  <= i_d_addr;
            // A write never reads back, even if the requester left rmask set.
            o_mem_rmask <= (|i_d_wmask) ? 8'h00 : i_d_rmask;
            o_mem_wmask <= i_d_wmask;
            o_mem_wdata <= i_d_wdata;
            if (!i_if_req)
              r_starve_cnt <= '0;
            else if (r_starve_cnt != c_limit)
              r_starve_cnt <= r_starve_cnt + 1'b1;
          end
        end
        ST_WAIT: begin
          if (i_mem_valid) begin
            if (r_owner_d) o_d_rdata  <= i_mem_rdata;
            else           o_if_rdata <= r_word_hi ? i_mem_rdata[63:32] : i_mem_rdata[31:0];
          end
        end
        ST_RESP: begin
          if (r_owner_d) o_d_valid  <= 1'b1;
          else           o_if_valid <= 1'b1;
        end
        default: ;
      endcase
    end
  end

  assign o_mem_req = (r_state == ST_REQ);
  assign o_busy    = (r_state != ST_IDLE);

endmodule
`default_nettype wire

// File: tb/tb_mem_arbiter.sv
`default_nettype none
// ---------------------------------------------------------------------------
// tb_mem_arbiter : directed self-checking bench for mem_arbiter
// Revision       : 1.0
// ---------------------------------------------------------------------------
module tb_mem_arbiter;

  logic        i_clk = 1'b0;
  logic        i_rst;
  logic        i_if_req;
  logic [63:0] i_if_addr;
  logic        o_if_gnt;
  logic        o_if_valid;
  logic [31:0] o_if_rdata;
  logic        i_d_req;
  logic [63:0] i_d_addr;
  logic [7:0]  i_d_rmask;
  logic [7:0]  i_d_wmask;
  logic [63:0] i_d_wdata;
  logic        o_d_gnt;
  logic        o_d_valid;
  logic [63:0] o_d_rdata;
  logic        o_mem_req;
  logic [63:0] o_mem_addr;
  logic [7:0]  o_mem_rmask;
  logic [7:0]  o_mem_wmask;
  logic [63:0] o_mem_wdata;
  logic        i_mem_ready;
  logic        i_mem_valid;
  logic [63:0] i_mem_rdata;
  logic        o_busy;

  int n_checks = 0;
  int n_fail   = 0;

  always #5 i_clk = ~i_clk;

  mem_arbiter #(.STARVE_LIMIT(4)) dut (
    .i_clk       (i_clk),
    .i_rst       (i_rst),
    .i_if_req    (i_if_req),
    .i_if_addr   (i_if_addr),
    .o_if_gnt    (o_if_gnt),
    .o_if_valid  (o_if_valid),
    .o_if_rdata  (o_if_rdata),
    .i_d_req     (i_d_req),
    .i_d_addr    (i_d_addr),
    .i_d_rmask   (i_d_rmask),
    .i_d_wmask   (i_d_wmask),
    .i_d_wdata   (i_d_wdata),
    .o_d_gnt     (o_d_gnt),
    .o_d_valid   (o_d_valid),
    .o_d_rdata   (o_d_rdata),
    .o_mem_req   (o_mem_req),
    .o_mem_addr  (o_mem_addr),
    .o_mem_rmask (o_mem_rmask),
    .o_mem_wmask (o_mem_wmask),
    .o_mem_wdata (o_mem_wdata),
    .i_mem_ready (i_mem_ready),
    .i_mem_valid (i_mem_valid),
    .i_mem_rdata (i_mem_rdata),
    .o_busy      (o_busy)
  );

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_checks++;
    if (obs !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h", tag, obs, exp);
    end
  endtask

  // Inputs change and outputs are sampled 1 time unit after each rising edge.
  task automatic step();
    @(posedge i_clk);
    #1;
  endtask

  // Runs REQ/WAIT/RESP with immediate ready and valid; ends on the valid-pulse cycle.
  task automatic complete(input logic [63:0] rd);
    i_mem_ready = 1'b1;
    step();
    i_mem_ready = 1'b0;
    i_mem_valid = 1'b1;
    i_mem_rdata = rd;
    step();
    i_mem_valid = 1'b0;
    step();
  endtask

  initial begin
    i_rst = 1'b1;
    i_if_req = 1'b0; i_if_addr = '0;
    i_d_req = 1'b0; i_d_addr = '0; i_d_rmask = '0; i_d_wmask = '0; i_d_wdata = '0;
    i_mem_ready = 1'b0; i_mem_valid = 1'b0; i_mem_rdata = '0;
    step();
    step();
    check("reset_busy",    64'(o_busy), 64'd0);
    check("reset_mem_req", 64'(o_mem_req), 64'd0);
    check("reset_gnts",    64'({o_if_gnt, o_d_gnt}), 64'd0);
    check("reset_valids",  64'({o_if_valid, o_d_valid}), 64'd0);
    check("reset_addr",    o_mem_addr, 64'd0);
    check("reset_masks",   64'({o_mem_rmask, o_mem_wmask}), 64'd0);
    check("reset_rdata",   o_d_rdata | 64'(o_if_rdata), 64'd0);
    i_rst = 1'b0;

    // Single fetch from the upper word
    i_if_req = 1'b1; i_if_addr = 64'h104;
    step();
    check("f_gnt",   64'(o_if_gnt), 64'd1);
    check("f_dgnt",  64'(o_d_gnt), 64'd0);
    check("f_req",   64'(o_mem_req), 64'd1);
    check("f_addr",  o_mem_addr, 64'h100);
    check("f_rmask", 64'(o_mem_rmask), 64'hF0);
    check("f_wmask", 64'(o_mem_wmask), 64'h00);
    i_if_req = 1'b0;
    complete(64'hAABBCCDD_11223344);
    check("f_valid", 64'(o_if_valid), 64'd1);
    check("f_rdata", 64'(o_if_rdata), 64'hAABBCCDD);
    check("f_idle",  64'(o_busy), 64'd0);
    step();
    check("f_valid_pulse", 64'(o_if_valid), 64'd0);
    check("f_rdata_hold",  64'(o_if_rdata), 64'hAABBCCDD);

    // Data write with memory stalling ready for 3 cycles
    i_d_req = 1'b1; i_d_addr = 64'h200; i_d_wmask = 8'hFF; i_d_rmask = 8'h0F; i_d_wdata = 64'h5;
    step();
    check("w_gnt",   64'(o_d_gnt), 64'd1);
    check("w_req",   64'(o_mem_req), 64'd1);
    check("w_rmask", 64'(o_mem_rmask), 64'h00);
    check("w_wmask", 64'(o_mem_wmask), 64'hFF);
    i_d_req = 1'b0; i_d_wdata = 64'hFFFF; i_d_addr = 64'h999;
    for (int i = 0; i < 3; i++) begin
      step();
      check("w_req_hold",  64'(o_mem_req), 64'd1);
      check("w_addr_hold", o_mem_addr, 64'h200);
      check("w_data_hold", o_mem_wdata, 64'h5);
      check("w_gnt_pulse", 64'(o_d_gnt), 64'd0);
      if (i == 2) i_mem_ready = 1'b1;
    end
    step();
    check("w_req_drop", 64'(o_mem_req), 64'd0);
    i_mem_ready = 1'b0; i_mem_valid = 1'b1; i_mem_rdata = 64'h1234;
    step();
    check("w_no_early_valid", 64'(o_d_valid), 64'd0);
    i_mem_valid = 1'b0;
    step();
    check("w_valid", 64'(o_d_valid), 64'd1);
    check("w_ack",   o_d_rdata, 64'h1234);
    step();
    check("w_valid_once", 64'(o_d_valid), 64'd0);

    // Simultaneous requests: data first, then the held fetch
    i_if_req = 1'b1; i_if_addr = 64'hC;
    i_d_req = 1'b1; i_d_addr = 64'h40; i_d_rmask = 8'hFF; i_d_wmask = 8'h00; i_d_wdata = 64'h0;
    step();
    check("s_first", 64'({o_if_gnt, o_d_gnt}), 64'b01);
    check("s_rmask", 64'(o_mem_rmask), 64'hFF);
    i_d_req = 1'b0;
    complete(64'h0123456789ABCDEF);
    check("s_dvalid", 64'(o_d_valid), 64'd1);
    check("s_drdata", o_d_rdata, 64'h0123456789ABCDEF);
    check("s_no_gnt_busy", 64'(o_if_gnt), 64'd0);
    step();
    check("s_second", 64'({o_if_gnt, o_d_gnt}), 64'b10);
    check("s_faddr",  o_mem_addr, 64'h8);
    check("s_frmask", 64'(o_mem_rmask), 64'hF0);
    i_if_req = 1'b0;
    complete(64'h11111111_22222222);
    check("s_frdata", 64'(o_if_rdata), 64'h11111111);

    // Starvation: both held, expect D,D,D,D,I,D,D,D,D,I
    i_if_req = 1'b1; i_if_addr = 64'h20;
    i_d_req = 1'b1; i_d_addr = 64'h80; i_d_rmask = 8'h01;
    for (int k = 0; k < 10; k++) begin
      step();
      check($sformatf("starve_gnt%0d", k), 64'({o_if_gnt, o_d_gnt}),
            (k == 4 || k == 9) ? 64'b10 : 64'b01);
      if (k == 9) begin
        i_if_req = 1'b0;
        i_d_req  = 1'b0;
      end
      complete(64'(k));
    end
    check("starve_last_if", 64'(o_if_valid), 64'd1);
    check("starve_last_rd", 64'(o_if_rdata), 64'd9);

    // Reset in WAIT, then a stale response while idle
    i_d_req = 1'b1; i_d_addr = 64'h300; i_d_rmask = 8'hFF; i_d_wmask = 8'h00;
    step();
    check("r_gnt", 64'(o_d_gnt), 64'd1);
    i_d_req = 1'b0;
    i_mem_ready = 1'b1;
    step();
    i_mem_ready = 1'b0;
    i_rst = 1'b1;
    step();
    i_rst = 1'b0;
    check("r_busy",   64'(o_busy), 64'd0);
    check("r_req",    64'(o_mem_req), 64'd0);
    check("r_drdata", o_d_rdata, 64'd0);
    i_mem_valid = 1'b1; i_mem_rdata = 64'hBAD0BAD0BAD0BAD0;
    for (int j = 0; j < 3; j++) begin
      step();
      check("r_stale_valid", 64'({o_if_valid, o_d_valid}), 64'd0);
      check("r_stale_busy",  64'(o_busy), 64'd0);
    end
    i_mem_valid = 1'b0;
    i_if_req = 1'b1; i_if_addr = 64'h300;
    step();
    check("r_next_gnt",   64'(o_if_gnt), 64'd1);
    check("r_next_addr",  o_mem_addr, 64'h300);
    check("r_next_rmask", 64'(o_mem_rmask), 64'h0F);
    i_if_req = 1'b0;
    complete(64'hDEADBEEF_CAFEF00D);
    check("r_next_valid", 64'(o_if_valid), 64'd1);
    check("r_next_rdata", 64'(o_if_rdata), 64'hCAFEF00D);
    check("r_next_drd",   o_d_rdata, 64'd0);

    $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
    $finish;
  end

endmodule
`default_nettype wire
